net_cfg_bridge: RTL and testbench



---
 rtl/net_cfg_bridge.sv | 275 +++++++++++++++++++++++++++
 tb/tb_net_cfg_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_cfg_bridge.sv
// net_cfg_bridge
// Memory-mapped configuration bridge on the PicoSoC iomem bus. The CPU fills
// 32-bit staging registers (key, action, index), then writes CMD. The bridge
// snapshots the staging state and replays it as single-cycle write pulses into
// the TCAM (value or mask plane), the action table and the default action.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   iomem_valid/ready     bus handshake, ready is a one-cycle acknowledge
//   iomem_wstrb           byte strobes, 0 = read
//   iomem_addr/wdata      byte address / write data
//   iomem_rdata           read data, valid while iomem_ready=1, 0 otherwise
//   tcam_wr_*             TCAM write port (addr, plane select, data, pulse)
//   action_wr_*           action table write port (pulse, addr, data)
//   action_wr_default     pulse when action_default_data is updated
//   action_default_data   held default action
//   cfg_busy              commit sequence in progress
//
// Register map (iomem_addr[5:2]):
//   0..3 KEY0..KEY3, 4 ACT_LO, 5 ACT_HI, 6 INDEX, 7 CMD/STATUS, others read 0.
//
// FSM states
//   state  | meaning
//   S_IDLE | no commit in progress
//   S_TCAM | TCAM write pulse on the outputs this cycle
//   S_ACT  | action table write pulse on the outputs this cycle
//   S_DEF  | default action update pulse on the outputs this cycle

module net_cfg_bridge #(
  parameter int         KEY_W    = 128,
  parameter int         ENTRIES  = 16,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter int         ACTION_W = 64,
  parameter logic [7:0] BASE_HI  = 8'h04
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic [IDX_W-1:0]    tcam_wr_addr,
  output logic                tcam_wr_is_mask,
  output logic [KEY_W-1:0]    tcam_wr_data,
  output logic                tcam_wr_en,
  output logic                action_wr_en,
  output logic [IDX_W-1:0]    action_wr_addr,
  output logic [ACTION_W-1:0] action_wr_data,
  output logic                action_wr_default,
  output logic [ACTION_W-1:0] action_default_data,
  output logic                cfg_busy
);

  localparam int KEY_WORDS = KEY_W / 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TCAM = 2'd1,
    S_ACT  = 2'd2,
    S_DEF  = 2'd3
  } state_t;

  // staging registers
  logic [3:0][31:0] key_word;
  logic [127:0]     key_flat;
  logic [31:0]      act_lo;
  logic [31:0]      act_hi;
  logic [31:0]      index_raw;
  logic             err;

  // request latched at selection, acted on in the acknowledge cycle
  logic             req_write;
  logic [3:0]       req_off;
  logic [3:0]       req_wstrb;
  logic [31:0]      req_wdata;

  // commit snapshot
  state_t              state;
  state_t              state_nxt;
  logic [KEY_W-1:0]    snap_key;
  logic [ACTION_W-1:0] snap_act;
  logic [IDX_W-1:0]    snap_idx;
  logic                snap_mask;
  logic                snap_t;
  logic                snap_a;
  logic                snap_d;

  logic                sel;
  logic                busy;
  logic                do_write;
  logic                cmd_we;
  logic                idx_oob;
  logic                needs_idx;
  logic                cmd_run;
  logic                err_set;
  logic                err_clr;
  logic                cmd_accept;
  logic [31:0]         rd_mux;
  logic [KEY_W-1:0]    src_key;
  logic [ACTION_W-1:0] src_act;
  logic [IDX_W-1:0]    src_idx;
  logic                src_mask;
  logic                unused_addr;

  assign unused_addr = ^{iomem_addr[23:6], iomem_addr[1:0]};

  assign key_flat  = key_word;
  assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
  assign busy      = (state != S_IDLE);
  assign cfg_busy  = busy;

  // all side effects of a write happen at the end of the acknowledge cycle
  assign do_write  = iomem_ready && req_write;
  assign cmd_we    = do_write && (req_off == 4'd7) && req_wstrb[0];
  assign err_clr   = do_write && (req_off == 4'd7) && req_wstrb[3] && req_wdata[31];

  // range check uses the full 32-bit INDEX so out-of-range values are not
  // hidden by truncation to IDX_W bits
  assign idx_oob   = (index_raw >= 32'(ENTRIES));
  assign needs_idx = req_wdata[0] | req_wdata[2];
  assign cmd_run   = req_wdata[0] | req_wdata[2] | req_wdata[3];
  assign err_set   = cmd_we && (busy ? (|req_wdata[3:0]) : (needs_idx && idx_oob));
  assign cmd_accept = cmd_we && !busy && cmd_run && !(needs_idx && idx_oob);

  // the first step of a sequence is loaded straight from staging, later
  // steps from the snapshot taken at the same edge
  assign src_key  = cmd_accept ? key_flat[KEY_W-1:0]        : snap_key;
  assign src_act  = cmd_accept ? ACTION_W'({act_hi, act_lo}) : snap_act;
  assign src_idx  = cmd_accept ? index_raw[IDX_W-1:0]       : snap_idx;
  assign src_mask = cmd_accept ? req_wdata[1]               : snap_mask;

  function automatic state_t next_step(input state_t cur, input logic do_t,
                                       input logic do_a, input logic do_d);
    next_step = S_IDLE;
    case (cur)
      S_IDLE: begin
        if (do_t)      next_step = S_TCAM;
        else if (do_a) next_step = S_ACT;
        else if (do_d) next_step = S_DEF;
      end
      S_TCAM: begin
        if (do_a)      next_step = S_ACT;
        else if (do_d) next_step = S_DEF;
      end
      S_ACT: begin
        if (do_d)      next_step = S_DEF;
      end
      default: next_step = S_IDLE;
    endcase
  endfunction

  assign state_nxt = cmd_accept ? next_step(S_IDLE, req_wdata[0], req_wdata[2], req_wdata[3])
                   : (busy ? next_step(state, snap_t, snap_a, snap_d) : S_IDLE);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      merge[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
    end
  endfunction

  always_comb begin
    rd_mux = '0;
    case (iomem_addr[5:2])
      4'd0, 4'd1, 4'd2, 4'd3: begin
        if (32'(iomem_addr[5:2]) < KEY_WORDS) rd_mux = key_word[iomem_addr[3:2]];
      end
      4'd4:    rd_mux = act_lo;
      4'd5:    rd_mux = act_hi;
      4'd6:    rd_mux = 32'(index_raw[IDX_W-1:0]);
      4'd7:    rd_mux = {30'b0, err, busy};
      default: rd_mux = '0;
    endcase
  end

  // bus interface and staging registers
  always_ff @(posedge clk) begin
    if (rst) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      req_write   <= 1'b0;
      req_off     <= '0;
      req_wstrb   <= '0;
      req_wdata   <= '0;
      key_word    <= '0;
      act_lo      <= '0;
      act_hi      <= '0;
      index_raw   <= '0;
      err         <= 1'b0;
    end else begin
      iomem_ready <= sel;
      if (sel) begin
        req_write   <= |iomem_wstrb;
        req_off     <= iomem_addr[5:2];
        req_wstrb   <= iomem_wstrb;
        req_wdata   <= iomem_wdata;
        iomem_rdata <= (iomem_wstrb == 4'b0) ? rd_mux : 32'b0;
      end else begin
        iomem_rdata <= '0;
      end

      if (do_write) begin
        case (req_off)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            if (32'(req_off) < KEY_WORDS)
              key_word[req_off[1:0]] <= merge(key_word[req_off[1:0]], req_wdata, req_wstrb);
          end
          4'd4:    act_lo    <= merge(act_lo, req_wdata, req_wstrb);
          4'd5:    act_hi    <= merge(act_hi, req_wdata, req_wstrb);
          4'd6:    index_raw <= merge(index_raw, req_wdata, req_wstrb);
          default: ;
        endcase
      end

      // a new error outranks a clear in the same cycle
      err <= err_set | (err & ~err_clr);
    end
  end

  // commit sequencer; outputs are registered from the next state so each
  // pulse lines up with the cycle its state is active
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      snap_key            <= '0;
      snap_act            <= '0;
      snap_idx            <= '0;
      snap_mask           <= 1'b0;
      snap_t              <= 1'b0;
      snap_a              <= 1'b0;
      snap_d              <= 1'b0;
      tcam_wr_en          <= 1'b0;
      tcam_wr_addr        <= '0;
      tcam_wr_data        <= '0;
      tcam_wr_is_mask     <= 1'b0;
      action_wr_en        <= 1'b0;
      action_wr_addr      <= '0;
      action_wr_data      <= '0;
      action_wr_default   <= 1'b0;
      action_default_data <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_accept) begin
        snap_key  <= key_flat[KEY_W-1:0];
        snap_act  <= ACTION_W'({act_hi, act_lo});
        snap_idx  <= index_raw[IDX_W-1:0];
        snap_mask <= req_wdata[1];
        snap_t    <= req_wdata[0];
        snap_a    <= req_wdata[2];
        snap_d    <= req_wdata[3];
      end

      tcam_wr_en <= (state_nxt == S_TCAM);
      if (state_nxt == S_TCAM) begin
        tcam_wr_addr    <= src_idx;
        tcam_wr_data    <= src_key;
        tcam_wr_is_mask <= src_mask;
      end

      action_wr_en <= (state_nxt == S_ACT);
      if (state_nxt == S_ACT) begin
        action_wr_addr <= src_idx;
        action_wr_data <= src_act;
      end

      action_wr_default <= (state_nxt == S_DEF);
      if (state_nxt == S_DEF) begin
        action_default_data <= src_act;
      end
    end
  end

endmodule

// File: tb/tb_net_cfg_bridge.sv
module tb_net_cfg_bridge;

  logic         clk;
  logic         rst;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_wdata;
  logic [31:0]  iomem_rdata;
  logic [3:0]   tcam_wr_addr;
  logic         tcam_wr_is_mask;
  logic [127:0] tcam_wr_data;
  logic         tcam_wr_en;
  logic         action_wr_en;
  logic [3:0]   action_wr_addr;
  logic [63:0]  action_wr_data;
  logic         action_wr_default;
  logic [63:0]  action_default_data;
  logic         cfg_busy;

  net_cfg_bridge dut (
    .clk                 (clk),
    .rst                 (rst),
    .iomem_valid         (iomem_valid),
    .iomem_ready         (iomem_ready),
    .iomem_wstrb         (iomem_wstrb),
    .iomem_addr          (iomem_addr),
    .iomem_wdata         (iomem_wdata),
    .iomem_rdata         (iomem_rdata),
    .tcam_wr_addr        (tcam_wr_addr),
    .tcam_wr_is_mask     (tcam_wr_is_mask),
    .tcam_wr_data        (tcam_wr_data),
    .tcam_wr_en          (tcam_wr_en),
    .action_wr_en        (action_wr_en),
    .action_wr_addr      (action_wr_addr),
    .action_wr_data      (action_wr_data),
    .action_wr_default   (action_wr_default),
    .action_default_data (action_default_data),
    .cfg_busy            (cfg_busy)
  );

  localparam logic [31:0] BASE    = 32'h0400_0000;
  localparam logic [31:0] A_KEY0  = BASE + 32'h00;
  localparam logic [31:0] A_KEY1  = BASE + 32'h04;
  localparam logic [31:0] A_KEY2  = BASE + 32'h08;
  localparam logic [31:0] A_KEY3  = BASE + 32'h0C;
  localparam logic [31:0] A_ALO   = BASE + 32'h10;
  localparam logic [31:0] A_AHI   = BASE + 32'h14;
  localparam logic [31:0] A_INDEX = BASE + 32'h18;
  localparam logic [31:0] A_CMD   = BASE + 32'h1C;
  localparam logic [127:0] KEY_V  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [63:0]  ACT_V  = 64'h0BADF00D_DEADBEEF;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int           kind;
    int           cyc;
    logic [3:0]   addr;
    logic [127:0] data;
    logic         mask;
  } exp_t;

  int   errors;
  int   checks;
  int   cyc;
  exp_t sb[$];
  vec_t vecs[20];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input int kind, input int c, input logic [3:0] a,
                          input logic [127:0] d, input logic m);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input int kind, input logic [3:0] a,
                             input logic [127:0] d, input logic m);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected no pulse", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", 128'(kind), 128'(e.kind));
      chk("pulse_cycle", 128'(cyc), 128'(e.cyc));
      chk("pulse_data", d, e.data);
      if (kind != 2) chk("pulse_addr", 128'(a), 128'(e.addr));
      if (kind == 0) chk("pulse_is_mask", 128'(m), 128'(e.mask));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (tcam_wr_en)        check_pulse(0, tcam_wr_addr, tcam_wr_data, tcam_wr_is_mask);
      if (action_wr_en)      check_pulse(1, action_wr_addr, {64'b0, action_wr_data}, 1'b0);
      if (action_wr_default) check_pulse(2, 4'd0, {64'b0, action_default_data}, 1'b0);
    end
  endtask

  // returns read data and the cycle number of the acknowledge cycle
  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int c);
    int n;
    bit got;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    n = 0;
    got = 0;
    while (!got && n < 4) begin
      @(negedge clk);
      n++;
      if (iomem_ready) got = 1;
    end
    chk("ready_latency", 128'(n), 128'd1);
    rd = iomem_rdata;
    c  = cyc;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int c);
    logic [31:0] rd;
    bus_xfer(a, 4'hF, d, rd, c);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] want);
    logic [31:0] rd;
    int c;
    bus_xfer(a, 4'h0, 32'h0, rd, c);
    chk(name, 128'(rd), 128'(want));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tcam_data"}, tcam_wr_data, 128'd0);
    chk({name, "_act_data"}, {action_wr_data, action_default_data}, 128'd0);
    chk({name, "_misc"}, 128'({iomem_ready, iomem_rdata, tcam_wr_addr, tcam_wr_is_mask,
                               tcam_wr_en, action_wr_en, action_wr_addr,
                               action_wr_default, cfg_busy}), 128'd0);
  endtask

  initial begin
    int c;
    logic [31:0] rd;

    vecs[0]  = '{A_KEY0,  4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[1]  = '{A_KEY0,  4'h1, 32'h000000AB, 32'h0};
    vecs[2]  = '{A_KEY0,  4'h0, 32'h0,        32'hFFFFFFAB};
    vecs[3]  = '{A_KEY0,  4'hF, 32'h11111111, 32'h0};
    vecs[4]  = '{A_KEY1,  4'hF, 32'h22222222, 32'h0};
    vecs[5]  = '{A_KEY2,  4'hF, 32'h33333333, 32'h0};
    vecs[6]  = '{A_KEY3,  4'hF, 32'h44444444, 32'h0};
    vecs[7]  = '{A_KEY0,  4'h0, 32'h0,        32'h11111111};
    vecs[8]  = '{A_KEY1,  4'h0, 32'h0,        32'h22222222};
    vecs[9]  = '{A_KEY2,  4'h0, 32'h0,        32'h33333333};
    vecs[10] = '{A_KEY3,  4'h0, 32'h0,        32'h44444444};
    vecs[11] = '{A_ALO,   4'h4, 32'h12345678, 32'h0};
    vecs[12] = '{A_ALO,   4'h0, 32'h0,        32'h00340000};
    vecs[13] = '{A_INDEX, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[14] = '{A_INDEX, 4'h0, 32'h0,        32'h0000000F};
    vecs[15] = '{BASE + 32'h20, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[16] = '{BASE + 32'h20, 4'h0, 32'h0,  32'h0};
    vecs[17] = '{BASE + 32'h3C, 4'h0, 32'h0,  32'h0};
    vecs[18] = '{A_INDEX, 4'hF, 32'h00000005, 32'h0};
    vecs[19] = '{A_INDEX, 4'h0, 32'h0,        32'h00000005};

    errors = 0;
    checks = 0;
    rst = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // reset STATUS read, ready must drop right after its single cycle
    rd_chk("status_after_reset", A_CMD, 32'h0);
    @(negedge clk);
    chk("ready_one_cycle", 128'(iomem_ready), 128'd0);

    // register access table
    for (int i = 0; i < 20; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, c);
      if (vecs[i].strb == 4'h0) chk($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp));
    end

    // single TCAM write at INDEX 5
    wr(A_CMD, 32'h1, c);
    push_exp(0, c + 1, 4'd5, KEY_V, 1'b0);
    wait_cyc(c + 1);
    chk("busy_c1_tcam", 128'(cfg_busy), 128'd1);
    wait_cyc(c + 2);
    chk("busy_c2_tcam", 128'(cfg_busy), 128'd0);

    // full sequence at the top index
    wr(A_ALO, 32'hDEADBEEF, c);
    wr(A_AHI, 32'h0BADF00D, c);
    wr(A_INDEX, 32'd15, c);
    wr(A_CMD, 32'hF, c);
    push_exp(0, c + 1, 4'd15, KEY_V, 1'b1);
    push_exp(1, c + 2, 4'd15, {64'b0, ACT_V}, 1'b0);
    push_exp(2, c + 3, 4'd0, {64'b0, ACT_V}, 1'b0);
    wait_cyc(c + 3);
    chk("busy_c3_full", 128'(cfg_busy), 128'd1);
    wait_cyc(c + 4);
    chk("busy_c4_full", 128'(cfg_busy), 128'd0);
    chk("default_held", 128'(action_default_data), 128'(ACT_V));

    // command while busy is dropped and sets ERR
    wr(A_CMD, 32'h7, c);
    push_exp(0, c + 1, 4'd15, KEY_V, 1'b1);
    push_exp(1, c + 2, 4'd15, {64'b0, ACT_V}, 1'b0);
    wr(A_CMD, 32'h1, c);
    repeat (4) @(negedge clk);
    rd_chk("status_busy_err", A_CMD, 32'h2);
    wr(A_CMD, 32'h8000_0000, c);
    rd_chk("status_cleared", A_CMD, 32'h0);

    // out-of-range index
    wr(A_INDEX, 32'd16, c);
    rd_chk("index_trunc", A_INDEX, 32'h0);
    wr(A_CMD, 32'h4, c);
    repeat (3) @(negedge clk);
    rd_chk("status_idx_err", A_CMD, 32'h2);
    wr(A_CMD, 32'h8000_0000, c);
    rd_chk("status_cleared2", A_CMD, 32'h0);

    // high bits out of range, clear and set together: set wins
    wr(A_INDEX, 32'h0001_0005, c);
    rd_chk("index_hi_bits", A_INDEX, 32'h5);
    wr(A_CMD, 32'h8000_0001, c);
    repeat (3) @(negedge clk);
    rd_chk("status_set_wins", A_CMD, 32'h2);
    wr(A_CMD, 32'h8000_0000, c);

    // default-only needs no index, so it still runs with INDEX out of range
    wr(A_CMD, 32'h8, c);
    push_exp(2, c + 1, 4'd0, {64'b0, ACT_V}, 1'b0);
    wait_cyc(c + 2);
    rd_chk("status_def_only", A_CMD, 32'h0);

    // no-op command never raises busy
    wr(A_INDEX, 32'd3, c);
    wr(A_CMD, 32'h2, c);
    wait_cyc(c + 1);
    chk("noop_busy", 128'(cfg_busy), 128'd0);
    rd_chk("status_noop", A_CMD, 32'h0);

    // reset during the action step aborts the rest of the sequence
    wr(A_CMD, 32'hD, c);
    push_exp(0, c + 1, 4'd3, KEY_V, 1'b0);
    push_exp(1, c + 2, 4'd3, {64'b0, ACT_V}, 1'b0);
    wait_cyc(c + 2);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_def", 128'(action_wr_default), 128'd0);
    rd_chk("status_after_abort", A_CMD, 32'h0);

    // foreign window never acknowledged
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("foreign_ready_%0d", i), 128'(iomem_ready), 128'd0);
    end
    iomem_valid = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
